// File: rtl/fifo_axis_pkg.sv
// Shared constants and types for the FIFO-to-AXI-Stream reader.
package fifo_axis_pkg;
   localparam int BUF_DEPTH       = 2;  // output buffer entries
   localparam int FIFO_RD_LATENCY = 1;  // cycles from fifo_read_en to fifo_data_out
   typedef logic [1:0] buf_count_t;     // occupancy 0..BUF_DEPTH
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry in-order output buffer. Entry 0 is always the head, so the
// stream data is a plain register read with no output mux on the pointer.
module axis_skid_buffer
   import fifo_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output buf_count_t            count,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
   buf_count_t                           count_q, count_d;
   buf_count_t                           level;
   logic                                 pop_ok, push_ok;

   // Pop shifts entry 1 down; push lands in the first free slot after the pop.
   always_comb begin
      mem_d   = mem_q;
      pop_ok  = pop && (count_q != '0);
      level   = count_q - {1'b0, pop_ok};
      push_ok = push && (level != buf_count_t'(BUF_DEPTH));
      if (pop_ok) begin
         mem_d[0] = mem_q[1];
         mem_d[1] = '0;
      end
      if (push_ok) begin
         if (level == '0) mem_d[0] = push_data;
         else             mem_d[1] = push_data;
      end
      count_d = level + {1'b0, push_ok};
   end

   // Buffer state register; reset flushes contents as well as the count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mem_q   <= '0;
         count_q <= '0;
      end else begin
         mem_q   <= mem_d;
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[0];

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a FIFO read port (1-cycle read latency) into an AXI-Stream master.
// Reads are issued only when the word is guaranteed a buffer slot on arrival.
module fifo_axis_reader
   import fifo_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_rd,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   input  logic                  fifo_empty,
   output logic                  fifo_read_en,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [1:0]            buf_count
);

   logic       inflight_q, inflight_d;
   logic       pop;
   logic [2:0] occupancy;
   buf_count_t count;

   assign pop = m_axis_tvalid & m_axis_tready;

   // Issue a read when buffered + in-flight words, net of this cycle's pop,
   // leave room; gated by reset so nothing is popped from the FIFO in reset.
   always_comb begin
      occupancy    = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_read_en = reset_n & ~fifo_empty & (occupancy < 3'(BUF_DEPTH));
      inflight_d   = fifo_read_en;
   end

   // In-flight flag: a read issued last cycle means fifo_data_out is valid now.
   always_ff @(posedge clk_rd) begin
      if (!reset_n) inflight_q <= 1'b0;
      else          inflight_q <= inflight_d;
   end

   axis_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk       (clk_rd),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data (fifo_data_out),
      .pop       (pop),
      .count     (count),
      .head_data (m_axis_tdata)
   );

   assign m_axis_tvalid = (count != '0);
   assign buf_count     = count;

endmodule

// File: doc/fifo_axis_reader.md
FIFO_AXIS_READER -- requirements
Module: fifo_axis_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and stream data.
REQ-002 clk_rd  input  1  read-domain clock; all logic SHALL be clocked on its rising edge (single clock).
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 fifo_data_out  input  DATA_WIDTH  FIFO read data, valid exactly one cycle after fifo_read_en.
REQ-005 fifo_empty  input  1  FIFO empty flag.
REQ-006 fifo_read_en  output  1  FIFO pop request.
REQ-007 m_axis_tdata  output  DATA_WIDTH  stream data.
REQ-008 m_axis_tvalid  output  1  stream valid.
REQ-009 m_axis_tready  input  1  stream ready from downstream.
REQ-010 buf_count  output  2  occupancy of internal output buffer, 0..2.

Function
REQ-011 The block SHALL drain the FIFO read port into an AXI-Stream master, preserving word order with no loss or duplication.
REQ-012 Internal state: 2-entry output buffer (FIFO order), buf_count, and 1-bit inflight register = fifo_read_en delayed one cycle.
REQ-013 pop = m_axis_tvalid & m_axis_tready; fifo_read_en SHALL = ~fifo_empty & ((buf_count + inflight - pop) < 2), combinational.
REQ-014 fifo_read_en SHALL never be high while fifo_empty is high or reset_n is low.
REQ-015 When inflight is 1, fifo_data_out SHALL be written into the buffer at that clock edge (push).
REQ-016 m_axis_tvalid SHALL = (buf_count != 0); m_axis_tdata SHALL present the oldest buffered word.
REQ-017 Push and pop on the same edge: buf_count unchanged, order preserved; push only: +1; pop only: -1.
REQ-018 buf_count + inflight SHALL never exceed 2; the buffer SHALL never overflow.
REQ-019 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tvalid SHALL hold stable.
REQ-020 Latency: fifo_read_en high in cycle N -> word captured at end of N+1 -> m_axis_tvalid high in N+2 (when buffer was empty).
REQ-021 Throughput: with fifo_empty=0 and m_axis_tready=1 continuously, steady state SHALL sustain 1 word per cycle.
REQ-022 Downstream stall: with m_axis_tready=0, at most 2 words SHALL be read ahead, then fifo_read_en SHALL stay low until a pop.
REQ-023 fifo_empty rising while inflight=1: the in-flight word SHALL still be captured; no further reads issued.

Reset
REQ-024 While reset_n=0 at a clock edge: buf_count=0, inflight=0, m_axis_tvalid=0, m_axis_tdata=0, buffer contents cleared.
REQ-025 Reset asserted mid-operation SHALL discard buffered and in-flight words; first edge after release SHALL behave as from empty.

Structure
REQ-026 Package fifo_axis_pkg SHALL hold BUF_DEPTH=2, FIFO_RD_LATENCY=1 and the buf_count typedef (2-bit unsigned).
REQ-027 The 2-entry buffer SHALL be a sub-module axis_skid_buffer (push/pop/count/head data); fifo_axis_reader holds read-issue and inflight logic.

Verification
REQ-028 Reset: hold reset_n=0 with fifo_empty=0 for 3 cycles -> fifo_read_en=0, m_axis_tvalid=0, buf_count=0 throughout.
REQ-029 Single word: fifo_empty falls in cycle 0 with data 0xA5, tready=1 -> fifo_read_en in cycle 0, tvalid with tdata=0xA5 in cycle 2, buf_count back to 0 in cycle 3.
REQ-030 Streaming: 16 words 0x00..0x0F, tready=1 -> 16 consecutive tvalid beats, in order, after 2-cycle initial latency.
REQ-031 Backpressure: FIFO holds 0x10..0x13, tready=0 for 10 cycles -> exactly 2 reads, buf_count=2, tdata=0x10 stable; tready=1 -> 0x10..0x13 in order.
REQ-032 Random tready (50%) and random fifo_empty over 1000 words -> scoreboard match, no read while empty, buf_count<=2, stability rule never violated.
REQ-033 Reset mid-stream: assert reset_n=0 with buf_count=2 and inflight=1 -> next cycle tvalid=0, buf_count=0; after release, next word read is the FIFO head.
